// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer
// Turns a raster-order grayscale pixel stream into 3x3 neighbourhoods for the
// Sobel stage. Two line buffers hold the previous two rows. A 3x3 register
// window shifts left by one column for every accepted pixel. A window is
// presented downstream for every interior pixel, and frame_done_o marks the
// acceptance of the last pixel of each frame.
module sobel_window_buffer #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 px_valid_i,
    input  logic [PIXEL_W-1:0]   px_gray_i,
    input  logic                 px_sof_i,
    output logic                 px_ready_o,
    output logic [9*PIXEL_W-1:0] window_o,
    output logic                 window_valid_o,
    input  logic                 window_ready_i,
    output logic                 frame_done_o
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [COL_W-1:0]   col_t;
    typedef logic [ROW_W-1:0]   row_t;

    localparam col_t LAST_COL = col_t'(IMG_W - 1);
    localparam row_t LAST_ROW = row_t'(IMG_H - 1);
    localparam col_t MIN_COL  = col_t'(2);
    localparam row_t MIN_ROW  = row_t'(2);

    // Raster position of the next pixel to be accepted.
    row_t   row_q, row_d;
    col_t   col_q, col_d;

    // 3x3 window: win_q[r][c], r=0 oldest row, c=0 leftmost column.
    pixel_t win_q [3][3];
    pixel_t win_d [3][3];

    // lineA holds row (current-2), lineB holds row (current-1), indexed by column.
    pixel_t line_a_q [IMG_W];
    pixel_t line_b_q [IMG_W];

    logic   window_valid_q, window_valid_d;
    logic   frame_done_q, frame_done_d;

    // Per-accept decode.
    logic   acc;
    row_t   eff_row;
    col_t   eff_col;
    pixel_t line_a_rd;
    pixel_t line_b_rd;
    logic   at_last_col;
    logic   at_last_row;
    logic   emit;

    // A pending window blocks new pixels unless it is being consumed now;
    // this is what keeps window_o stable while downstream stalls.
    assign px_ready_o = ~window_valid_q | window_ready_i;
    assign acc        = px_valid_i & px_ready_o;

    // Start-of-frame forces the accepted pixel to (0,0); it only has an
    // effect when the pixel is actually accepted, since all state updates
    // below are gated by acc.
    assign eff_row = px_sof_i ? '0 : row_q;
    assign eff_col = px_sof_i ? '0 : col_q;

    assign line_a_rd = line_a_q[eff_col];
    assign line_b_rd = line_b_q[eff_col];

    assign at_last_col = (eff_col == LAST_COL);
    assign at_last_row = (eff_row == LAST_ROW);

    // Rows 0-1 and columns 0-1 only prime the window; from (2,2) on every
    // accepted pixel completes a window centred one row up and one column left.
    assign emit = (eff_row >= MIN_ROW) && (eff_col >= MIN_COL);

    // Next-state logic for counters, window shift register and output flags.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        row_d          = row_q;
        col_d          = col_q;
        win_d          = win_q;
        window_valid_d = window_valid_q & ~window_ready_i;
        frame_done_d   = 1'b0;

        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line_a_rd;
            win_d[1][2] = line_b_rd;
            win_d[2][2] = px_gray_i;

            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : eff_row + row_t'(1);
            end else begin
                col_d = eff_col + col_t'(1);
                row_d = eff_row;
            end

            if (emit) begin
                window_valid_d = 1'b1;
            end

            frame_done_d = at_last_col & at_last_row;
        end
    end

    // Control and window registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            row_q          <= '0;
            col_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            row_q          <= row_d;
            col_q          <= col_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            win_q          <= win_d;
        end
    end

    // Line buffer update: the column being accepted moves up one row.
    always_ff @(posedge clk_i) begin
        // NOTE: the line buffers are deliberately left out of reset; rows 0-1 overwrite every column before any window reads them.
        if (acc) begin
            line_a_q[eff_col] <= line_b_rd;
            line_b_q[eff_col] <= px_gray_i;
        end
    end

    // Pack the window: w[r][c] lands at PIXEL_W*(3*r+c).
    always_comb begin
        window_o = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_o[PIXEL_W*(3*r+c) +: PIXEL_W] = win_q[r][c];
            end
        end
    end

    assign window_valid_o = window_valid_q;
    assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed testbench for sobel_window_buffer.
// Instance A: 4x4 frames (streaming, backpressure, back-to-back frames,
// mid-frame sof, mid-frame reset). Instance B: 6x5 frames with random input
// gaps and random downstream ready.
module tb_sobel_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A (4x4) ----------------
    logic        a_reset, a_valid, a_sof, a_wready;
    logic [7:0]  a_gray;
    logic        a_pxready, a_wvalid, a_fdone;
    logic [71:0] a_window;

    sobel_window_buffer #(.PIXEL_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk_i          (clk),
        .reset_i        (a_reset),
        .px_valid_i     (a_valid),
        .px_gray_i      (a_gray),
        .px_sof_i       (a_sof),
        .px_ready_o     (a_pxready),
        .window_o       (a_window),
        .window_valid_o (a_wvalid),
        .window_ready_i (a_wready),
        .frame_done_o   (a_fdone)
    );

    // ---------------- instance B (6x5) ----------------
    logic        b_reset, b_valid, b_sof, b_wready;
    logic [7:0]  b_gray;
    logic        b_pxready, b_wvalid, b_fdone;
    logic [71:0] b_window;

    sobel_window_buffer #(.PIXEL_W(8), .IMG_W(6), .IMG_H(5)) dut_b (
        .clk_i          (clk),
        .reset_i        (b_reset),
        .px_valid_i     (b_valid),
        .px_gray_i      (b_gray),
        .px_sof_i       (b_sof),
        .px_ready_o     (b_pxready),
        .window_o       (b_window),
        .window_valid_o (b_wvalid),
        .window_ready_i (b_wready),
        .frame_done_o   (b_fdone)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected window centred at (r,c) for a frame whose pixel is base+16*row+col.
    function automatic logic [71:0] exp_win(input logic [7:0] base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = base + 8'(16*(r-1+i) + (c-1+j));
        return w;
    endfunction

    // ---------------- handshake monitors ----------------
    logic [71:0] a_q[$];
    int          a_fd_cnt = 0;
    int          a_fd_lonely = 0;

    always @(negedge clk) begin
        if (a_wvalid && a_wready) a_q.push_back(a_window);
        if (a_fdone) begin
            a_fd_cnt++;
            if (!a_wvalid) a_fd_lonely++;
        end
    end

    logic [71:0] b_q[$];
    int          b_fd_cnt = 0;
    bit          b_prev_stall = 1'b0;
    logic [71:0] b_prev_win;

    always @(negedge clk) begin
        check("b_px_ready", 72'(b_pxready), 72'(!b_wvalid || b_wready));
        if (b_prev_stall) begin
            check("b_hold_valid", 72'(b_wvalid), 72'(1));
            check("b_hold_window", b_window, b_prev_win);
        end
        b_prev_stall = b_wvalid && !b_wready;
        b_prev_win   = b_window;
        if (b_wvalid && b_wready) b_q.push_back(b_window);
        if (b_fdone) b_fd_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_gray  = d;
        a_sof   = sof;
        @(negedge clk);
        while (!a_pxready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_accept", 72'(a_pxready), 72'(1));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_sof   = 1'b0;
    endtask

    task automatic a_frame(input logic [7:0] base, input bit sof_first, input bit step_check);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a_send(base + 8'(16*r + c), sof_first && r == 0 && c == 0);
                if (step_check) begin
                    check("a_wvalid_after_acc", 72'(a_wvalid), 72'(r >= 2 && c >= 2));
                    if (r >= 2 && c >= 2)
                        check("a_window_after_acc", a_window, exp_win(base, r-1, c-1));
                    check("a_fdone_after_acc", 72'(a_fdone), 72'(r == 3 && c == 3));
                end
            end
        end
    endtask

    task automatic a_expect_frame(input logic [7:0] base);
        logic [71:0] got;
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 2; c++) begin
                got = (a_q.size() > 0) ? a_q.pop_front() : 'x;
                check("a_window", got, exp_win(base, r, c));
            end
        end
    endtask

    task automatic a_clear();
        a_q.delete();
        a_fd_cnt    = 0;
        a_fd_lonely = 0;
    endtask

    task automatic b_send(input logic [7:0] d, input logic sof);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while ($urandom_range(0, 1) == 1) begin
            b_valid  = 1'b0;
            b_wready = 1'($urandom_range(0, 1));
            tick(1);
        end
        b_valid = 1'b1;
        b_gray  = d;
        b_sof   = sof;
        do begin
            b_wready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = b_pxready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        check("b_accept", 72'(ok), 72'(1));
        b_valid = 1'b0;
        b_sof   = 1'b0;
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [71:0] got;

        a_reset = 1'b1; a_valid = 1'b0; a_sof = 1'b0; a_gray = '0; a_wready = 1'b1;
        b_reset = 1'b1; b_valid = 1'b0; b_sof = 1'b0; b_gray = '0; b_wready = 1'b0;
        tick(3);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wvalid", 72'(a_wvalid), 72'(0));
        check("rst_fdone", 72'(a_fdone), 72'(0));
        check("rst_window", a_window, 72'(0));
        check("rst_px_ready", 72'(a_pxready), 72'(1));
        @(posedge clk);
        #1;
        a_clear();

        // Streaming frame with window_ready held high
        a_frame(8'h00, 1'b1, 1'b1);
        tick(2);
        check("t1_count", 72'(a_q.size()), 72'(4));
        a_expect_frame(8'h00);
        check("t1_fdone_count", 72'(a_fd_cnt), 72'(1));
        check("t1_fdone_with_window", 72'(a_fd_lonely), 72'(0));
        a_clear();

        // Backpressure on the first window, then a back-to-back second frame
        a_wready = 1'b0;
        for (int i = 0; i < 11; i++) a_send(8'(16*(i/4) + i%4), i == 0);
        a_valid = 1'b1;
        a_gray  = 8'h23;
        a_sof   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_px_ready", 72'(a_pxready), 72'(0));
            check("bp_wvalid", 72'(a_wvalid), 72'(1));
            check("bp_window_held", a_window, exp_win(8'h00, 1, 1));
            @(posedge clk);
            #1;
        end
        a_wready = 1'b1;
        for (int i = 11; i < 16; i++) a_send(8'(16*(i/4) + i%4), 1'b0);
        a_frame(8'h80, 1'b1, 1'b0);
        tick(2);
        check("t2_count", 72'(a_q.size()), 72'(8));
        a_expect_frame(8'h00);
        a_expect_frame(8'h80);
        check("t2_fdone_count", 72'(a_fd_cnt), 72'(2));
        check("t2_fdone_with_window", 72'(a_fd_lonely), 72'(0));
        a_clear();

        // Mid-frame sof on pixel (1,2): aborted frame gives no frame_done
        for (int i = 0; i < 6; i++) a_send(8'h40 + 8'(16*(i/4) + i%4), 1'b0);
        a_frame(8'hC0, 1'b1, 1'b0);
        tick(2);
        check("t3_count", 72'(a_q.size()), 72'(4));
        a_expect_frame(8'hC0);
        check("t3_fdone_count", 72'(a_fd_cnt), 72'(1));
        a_clear();

        // Reset pulse right after accepting (2,3) while a window is valid
        for (int i = 0; i < 12; i++) a_send(8'(16*(i/4) + i%4), i == 0);
        check("t4_pre_wvalid", 72'(a_wvalid), 72'(1));
        check("t4_pre_window", a_window, exp_win(8'h00, 1, 2));
        a_reset = 1'b1;
        tick(1);
        a_reset = 1'b0;
        check("t4_post_rst_wvalid", 72'(a_wvalid), 72'(0));
        check("t4_post_rst_window", a_window, 72'(0));
        a_clear();
        a_frame(8'h80, 1'b0, 1'b0);
        tick(2);
        check("t4_count", 72'(a_q.size()), 72'(4));
        a_expect_frame(8'h80);
        check("t4_fdone_count", 72'(a_fd_cnt), 72'(1));
        a_clear();

        // Random gaps and random downstream ready, 6x5 frames
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 6; c++) begin
                    b_send(8'(f*8'h80) + 8'(16*r + c), r == 0 && c == 0);
                end
            end
        end
        b_valid  = 1'b0;
        b_wready = 1'b1;
        tick(4);
        check("b_count", 72'(b_q.size()), 72'(24));
        for (int f = 0; f < 2; f++) begin
            for (int r = 1; r <= 3; r++) begin
                for (int c = 1; c <= 4; c++) begin
                    got = (b_q.size() > 0) ? b_q.pop_front() : 'x;
                    check("b_window", got, exp_win(8'(f*8'h80), r, c));
                end
            end
        end
        check("b_fdone_count", 72'(b_fd_cnt), 72'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
